// File: rtl/decoder_3to8_reg.sv
// ============================================================================
// decoder_3to8_reg
//
// Registered 3-to-8 one-hot decoder with an active-high enable. The 3-bit
// select code is turned into a one-hot line vector and captured in a single
// output register, so downstream logic sees a glitch-free select bus with one
// clock of latency and no combinational path from the inputs.
//
// Parameters:
//   ACTIVE_LOW  0: selected line is 1, all others 0 (idle value 8'h00)
//               1: whole vector inverted, selected line is 0 (idle 8'hFF)
//
// Ports:
//   clk     in   1  system clock, rising edge
//   rst_n   in   1  asynchronous active-low reset, forces y to the idle value
//   a       in   3  select code 0..7
//   enable  in   1  decode enable, active-high; when low no line is active
//   y       out  8  registered select vector, bit i corresponds to code i
// ============================================================================
module decoder_3to8_reg #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] a,
    input  logic       enable,
    output logic [7:0] y
);

    // Value of y when no line is selected; also the reset value.
    localparam logic [7:0] IDLE_VALUE = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0] decode_d;
    logic [7:0] y_d;
    logic [7:0] y_q;

    // Active-high one-hot decode: a single bit set at position a while
    // enabled, nothing set otherwise. Polarity is applied afterwards so the
    // decode itself is independent of ACTIVE_LOW.
    always_comb begin
        decode_d = 8'h00;
        if (enable) begin
            decode_d[a] = 1'b1;
        end
    end

    // Output polarity. Inverting the whole vector keeps the one-hot property
    // in the active-low sense (exactly one 0 while enabled).
    always_comb begin
        y_d = decode_d;
        if (ACTIVE_LOW) begin
            y_d = ~decode_d;
        end
    end

    // The only state in the block. Reset drops any decode in flight and
    // parks the bus at its idle value immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= IDLE_VALUE;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_decoder_3to8_reg.sv
// ============================================================================
// tb_decoder_3to8_reg
//
// Self-checking bench for decoder_3to8_reg. Two instances share all inputs:
// one with ACTIVE_LOW = 0 and one with ACTIVE_LOW = 1. Expected outputs come
// from a behavioural model that computes the selected line as a power of two
// and derives the inverted form arithmetically.
// ============================================================================
module tb_decoder_3to8_reg;

    logic       clk;
    logic       rst_n;
    logic [2:0] a;
    logic       enable;
    logic [7:0] yHigh;
    logic [7:0] yLow;

    int testsRun;
    int testsFailed;

    decoder_3to8_reg #(.ACTIVE_LOW(1'b0)) dutHigh (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .enable (enable),
        .y      (yHigh)
    );

    decoder_3to8_reg #(.ACTIVE_LOW(1'b1)) dutLow (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .enable (enable),
        .y      (yLow)
    );

    // 100 MHz-style free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: the selected line carries weight 2**code; the
    // active-low form is the complement within 8 bits (255 minus the value).
    function automatic logic [7:0] modelY(input bit en, input int code, input bit activeLow);
        int weight;
        weight = en ? (2 ** code) : 0;
        if (activeLow) begin
            return 8'(255 - weight);
        end
        return 8'(weight);
    endfunction

    // Reset asserted with an active decode on the inputs: the idle value must
    // appear without any clock edge, hold across an edge, and the first edge
    // after release must load the decode of the present inputs.
    task automatic test_reset();
        logic [7:0] expHigh;
        logic [7:0] expLow;
        enable = 1'b1;
        a      = 3'b101;
        #2 rst_n = 1'b0;
        #1;
        testsRun++;
        if (yHigh !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL reset_async_high: y=%h expected %h", yHigh, 8'h00);
        end
        testsRun++;
        if (yLow !== 8'hFF) begin
            testsFailed++;
            $display("[TB] FAIL reset_async_low: y=%h expected %h", yLow, 8'hFF);
        end
        @(posedge clk);
        #1;
        testsRun++;
        if (yHigh !== 8'h00 || yLow !== 8'hFF) begin
            testsFailed++;
            $display("[TB] FAIL reset_hold: yHigh=%h yLow=%h expected 00/ff", yHigh, yLow);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expHigh = modelY(1'b1, 5, 1'b0);
        expLow  = modelY(1'b1, 5, 1'b1);
        testsRun++;
        if (yHigh !== expHigh) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_high: y=%h expected %h", yHigh, expHigh);
        end
        testsRun++;
        if (yLow !== expLow) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_low: y=%h expected %h", yLow, expLow);
        end
    endtask

    // Enable held low while the code sweeps: the bus must stay idle.
    task automatic test_disabled();
        for (int i = 0; i < 8; i++) begin
            enable = 1'b0;
            a      = 3'(i);
            @(posedge clk);
            #1;
            testsRun++;
            if (yHigh !== 8'h00 || yLow !== 8'hFF) begin
                testsFailed++;
                $display("[TB] FAIL disabled_code%0d: yHigh=%h yLow=%h expected 00/ff", i, yHigh, yLow);
            end
        end
    endtask

    // All eight codes on consecutive cycles with a one-cycle lag; the output
    // must match the model and carry exactly one active line.
    task automatic test_sweep();
        logic [7:0] expHigh;
        logic [7:0] expLow;
        for (int i = 0; i < 8; i++) begin
            enable = 1'b1;
            a      = 3'(i);
            @(posedge clk);
            #1;
            expHigh = modelY(1'b1, i, 1'b0);
            expLow  = modelY(1'b1, i, 1'b1);
            testsRun++;
            if (yHigh !== expHigh) begin
                testsFailed++;
                $display("[TB] FAIL sweep_high_code%0d: y=%h expected %h", i, yHigh, expHigh);
            end
            testsRun++;
            if (yLow !== expLow) begin
                testsFailed++;
                $display("[TB] FAIL sweep_low_code%0d: y=%h expected %h", i, yLow, expLow);
            end
            testsRun++;
            if ($countones(yHigh) != 1 || $countones(~yLow) != 1) begin
                testsFailed++;
                $display("[TB] FAIL sweep_onehot_code%0d: yHigh=%h yLow=%h expected one active line", i, yHigh, yLow);
            end
        end
    endtask

    // Code 3 held while enable goes 1, 0, 1 on consecutive cycles.
    task automatic test_enable_toggle();
        bit enSeq [3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0] expHigh;
        logic [7:0] expLow;
        a = 3'b011;
        for (int i = 0; i < 3; i++) begin
            enable = enSeq[i];
            @(posedge clk);
            #1;
            expHigh = modelY(enSeq[i], 3, 1'b0);
            expLow  = modelY(enSeq[i], 3, 1'b1);
            testsRun++;
            if (yHigh !== expHigh || yLow !== expLow) begin
                testsFailed++;
                $display("[TB] FAIL enable_toggle_step%0d: yHigh=%h yLow=%h expected %h/%h", i, yHigh, yLow, expHigh, expLow);
            end
        end
    endtask

    // Sweep up to code 4 (y = 8'h10), then pulse reset between edges with
    // code 5 already on the inputs. The pending decode is dropped; the next
    // edge after release shows the decode of the inputs present then.
    task automatic test_async_midstream();
        logic [7:0] expHigh;
        logic [7:0] expLow;
        enable = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            a = 3'(i);
            @(posedge clk);
            #1;
        end
        testsRun++;
        if (yHigh !== 8'h10) begin
            testsFailed++;
            $display("[TB] FAIL midstream_before: y=%h expected %h", yHigh, 8'h10);
        end
        a = 3'd5;
        #2 rst_n = 1'b0;
        #1;
        testsRun++;
        if (yHigh !== 8'h00 || yLow !== 8'hFF) begin
            testsFailed++;
            $display("[TB] FAIL midstream_reset: yHigh=%h yLow=%h expected 00/ff", yHigh, yLow);
        end
        #1 rst_n = 1'b1;
        a = 3'd6;
        @(posedge clk);
        #1;
        expHigh = modelY(1'b1, 6, 1'b0);
        expLow  = modelY(1'b1, 6, 1'b1);
        testsRun++;
        if (yHigh !== expHigh || yLow !== expLow) begin
            testsFailed++;
            $display("[TB] FAIL midstream_after: yHigh=%h yLow=%h expected %h/%h", yHigh, yLow, expHigh, expLow);
        end
    endtask

    // Random codes, enables and occasional reset pulses between edges.
    task automatic test_random();
        logic [7:0] expHigh;
        logic [7:0] expLow;
        int         code;
        bit         en;
        for (int i = 0; i < 200; i++) begin
            code   = int'($urandom_range(7, 0));
            en     = 1'($urandom_range(1, 0));
            a      = 3'(code);
            enable = en;
            if ($urandom_range(9, 0) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                testsRun++;
                if (yHigh !== 8'h00 || yLow !== 8'hFF) begin
                    testsFailed++;
                    $display("[TB] FAIL random_reset_iter%0d: yHigh=%h yLow=%h expected 00/ff", i, yHigh, yLow);
                end
                #1 rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
            expHigh = modelY(en, code, 1'b0);
            expLow  = modelY(en, code, 1'b1);
            testsRun++;
            if (yHigh !== expHigh || yLow !== expLow) begin
                testsFailed++;
                $display("[TB] FAIL random_iter%0d: a=%0d en=%0b yHigh=%h yLow=%h expected %h/%h",
                         i, code, en, yHigh, yLow, expHigh, expLow);
            end
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b1;
        a           = 3'd0;
        enable      = 1'b0;
        test_reset();
        test_disabled();
        test_sweep();
        test_enable_toggle();
        test_async_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
